// File: rtl/uart_tx.sv
// uart_tx: pops one byte per frame from the TX FIFO and shifts it out LSB-first on txd as 8N1/8N2.
// Start bit follows the pop decision by 3 clocks; the FIFO is read only from IDLE and never while empty.
module uart_tx #(
  parameter int DATA_SIZE = 8,
  parameter int DIV_SIZE  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tx_en,
  input  logic                 nstop,
  input  logic [DIV_SIZE-1:0]  div,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 txd,
  output logic                 busy
);
  localparam int BW = $clog2(DATA_SIZE) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_SIZE - 1);

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;

  state_t               state_q;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic [DIV_SIZE-1:0]  baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DIV_SIZE-1:0]  div_q;
  logic                 nstop_q;
  logic                 txd_q, rd_en_q, busy_q;
  logic                 bit_end;

  always_comb begin
    shift_d = shift_q >> 1;
    baud_d  = baud_q + DIV_SIZE'(1);
    bit_d   = bit_q + BW'(1);
    bit_end = (baud_q == div_q);
  end

  // Frame config is frozen at LOAD so mid-frame div/nstop changes only affect the next byte.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      nstop_q <= 1'b0;
      txd_q   <= 1'b1;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (tx_en && !fifo_empty) begin
            state_q <= POP;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        POP: state_q <= LOAD;
        LOAD: begin
          shift_q <= fifo_rd_data;
          div_q   <= div;
          nstop_q <= nstop;
          baud_q  <= '0;
          txd_q   <= 1'b0;
          state_q <= START;
        end
        START: begin
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_d;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q  <= '0;
            shift_q <= shift_d;
            if (bit_q == LAST_BIT) begin
              bit_q   <= '0;
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q <= bit_d;
              txd_q <= shift_d[0];
            end
          end else begin
            baud_q <= baud_d;
          end
        end
        STOP: begin
          // bit_q counts completed stop bits.
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == {{(BW-1){1'b0}}, nstop_q}) begin
              bit_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              bit_q <= bit_d;
            end
          end else begin
            baud_q <= baud_d;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign txd        = txd_q;
  assign busy       = busy_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmit engine that drains the TX FIFO and serialises each byte onto the `txd` line as an 8N1 or 8N2 frame. It sits between the peripheral's TX `fifo` instance and the pin. It is the FIFO's read-side consumer, the counterpart of the RX path that fills the RX FIFO.

## Interface
Parameters:
- `DATA_SIZE`, 8: frame data bits. Must equal the TX FIFO `DATA_SIZE`.
- `DIV_SIZE`, 16: width of the baud divisor.

Ports:
- `clock`, input, 1: system clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `tx_en`, input, 1: transmitter enable.
- `nstop`, input, 1: stop-bit select. 0 gives 1 stop bit; 1 gives 2 stop bits.
- `div`, input, `DIV_SIZE`: baud divisor. One bit period is `div`+1 clocks.
- `fifo_empty`, input, 1: TX FIFO `empty` flag.
- `fifo_rd_data`, input, `DATA_SIZE`: TX FIFO `rd_data`. It is valid in the cycle after `fifo_rd_en` is sampled high.
- `fifo_rd_en`, output, 1: pop request to the TX FIFO `rd_en`.
- `txd`, output, 1: serial line. Idle is high.
- `busy`, output, 1: high while the FSM is in any state other than IDLE.

## Operation
- Registers:
  - 3-bit state register.
  - `DATA_SIZE`-bit shift register.
  - `DIV_SIZE`-bit baud counter.
  - Bit counter of width $clog2(`DATA_SIZE`)+1.
  - Latched `div_q` and `nstop_q`.
- All outputs are registered or Moore-decoded from state. No input-to-output combinational path.
- States and transitions:
  - IDLE: `txd`=1. If `tx_en` && !`fifo_empty`, go to POP. Otherwise stay.
  - POP: `fifo_rd_en`=1 for exactly this one cycle. Go to LOAD.
  - LOAD: capture `fifo_rd_data` into the shift register. Latch `div_q`<=`div` and `nstop_q`<=`nstop`. Clear the baud counter. Go to START.
  - START: `txd`=0 for `div_q`+1 cycles. Then clear the bit counter and go to DATA.
  - DATA: `txd` = shift register bit 0 (LSB first). Every `div_q`+1 cycles, shift right and increment the bit counter. After `DATA_SIZE` bits, go to STOP.
  - STOP: `txd`=1 for (`nstop_q`+1)×(`div_q`+1) cycles. Then go to IDLE.
- Baud counter rules:
  - Counts 0..`div_q` and wraps to 0.
  - The bit boundary is at the count == `div_q` cycle.
  - Compare at full `DIV_SIZE` width; no overflow occurs.
- `div`=0 is legal. Each bit then lasts one clock.
- `div`/`nstop` changes while busy have no effect on the current frame. They apply at the next LOAD.
- `tx_en` deasserted mid-frame: the current frame completes, then the FSM stays in IDLE.
- `fifo_empty` is sampled only in IDLE.
- Exactly one pop per frame. The engine never pops when `fifo_empty`=1.
- Reset asserted at any point, including mid-frame, has the same required effect on the next rising edge:
  - State goes to IDLE.
  - `txd`=1, `fifo_rd_en`=0, `busy`=0.
  - Shift register and all counters are cleared.

## Timing
- Reset values: `txd`=1, `fifo_rd_en`=0, `busy`=0.
- Start-bit latency: `txd` falls 3 cycles after the edge at which IDLE samples `tx_en`=1 && `fifo_empty`=0. Those 3 cycles are the IDLE→POP, POP→LOAD and LOAD→START edges.
- Frame length: (1 + `DATA_SIZE` + `nstop`+1)×(`div`+1) cycles.
  - 8N1 at `div`=3: 40 cycles.
  - 8N2 at `div`=3: 44 cycles.
- Back-to-back frames: the gap between the last stop-bit cycle and the next start bit is exactly 3 cycles of `txd`=1 (IDLE, POP, LOAD).
- `busy` rises on the IDLE→POP edge. It falls on the STOP→IDLE edge.

## Test plan
- Reset checks:
  - Hold `reset`=0 for 2 cycles, then release it → `txd`=1, `busy`=0, `fifo_rd_en`=0.
  - With `fifo_empty`=1 and `tx_en`=1, no pop occurs over 100 cycles.
- Single byte: FIFO holds 0xA5, `div`=3, `nstop`=0.
  - Exactly one `fifo_rd_en` pulse.
  - `txd` sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each level held 4 cycles.
  - `busy` drops after the stop bit.
- Two stop bits, back-to-back: FIFO holds 0x00, 0xFF, `nstop`=1, `div`=0.
  - Frames are 11 cycles each.
  - Exactly 3 idle-high cycles between frames.
  - Two pops total.
  - `fifo_empty` becomes 1 afterwards and no further pop occurs.
- Mid-frame config change and disable:
  - Change `div` 3→7 and drop `tx_en` during frame 1 DATA → frame 1 keeps 4-cycle bits and completes.
  - No second pop while `tx_en`=0.
  - Re-assert `tx_en` → frame 2 uses 8-cycle bits.
- Reset mid-frame: assert `reset`=0 during DATA bit 4 of 0x3C.
  - Next edge gives `txd`=1, `busy`=0.
  - After release with the FIFO still non-empty, the next entry is sent with a full, correct frame.
- Randomised scoreboard: 1000 random bytes through a real `fifo` instance (`DEPTH`=8) with random `div` in 0..5, `nstop`, and `tx_en`.
  - A sampling receiver model recovers every byte in order.
  - No pop while empty.
